// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding,
// port index constants and the burst counter width.
package data_mem_arbiter_pkg;

  // Arbiter ownership state: which port (if any) was granted last cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int PORT0       = 0;
  localparam int PORT1       = 1;
  localparam int BURST_CNT_W = 4;

  // Next ownership state from the pair of grants issued this cycle
  function automatic arb_state_e next_owner(input logic g0, input logic g1);
    arb_state_e nxt;
    nxt = ST_IDLE;
    if (g0)      nxt = ST_OWN0;
    else if (g1) nxt = ST_OWN1;
    return nxt;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select for the two-port data memory arbiter.
// Default build: fixed priority to port 0, with port 1 forced through once
// port 0 has taken MAX_BURST consecutive grants while port 1 waited.
// Build option ARB_ROUND_ROBIN_EN: on dual requests alternate relative to the
// last owner (IDLE counts as "give port 0").
module arb_pick
  import data_mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                   p0_req,
  input  logic                   p1_req,
  input  logic [1:0]             state,
  input  logic [BURST_CNT_W-1:0] burst_cnt,
  output logic                   pick0,
  output logic                   pick1
);

  localparam logic [BURST_CNT_W-1:0] BURST_CAP = BURST_CNT_W'(MAX_BURST);

  logic burst_full;
  logic last_was_p0;

  assign burst_full  = (burst_cnt == BURST_CAP);
  assign last_was_p0 = (state == ST_OWN0);

`ifdef ARB_ROUND_ROBIN_EN
  logic unused_burst;
  assign unused_burst = burst_full;

  // Round-robin: on contention hand the grant to the port that did not own last
  always_comb begin
    pick0 = p0_req & (~p1_req | ~last_was_p0);
    pick1 = p1_req & (~p0_req |  last_was_p0);
  end
`else
  logic unused_state;
  assign unused_state = last_was_p0;

  // Fixed priority: port 0 wins contention unless its burst allowance is spent
  always_comb begin
    pick0 = p0_req & ~(p1_req & burst_full);
    pick1 = p1_req & (~p0_req | burst_full);
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a single-ported data memory
// with combinational read data. Port 0 is the CPU load/store path, port 1 the
// loader/debug path. Grants are combinational from state and requests; read
// data returns registered one cycle after the grant.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of fixed priority with a port-0 burst cap.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [WIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0] p0_wdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [WIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p0_gnt,
  output logic             p1_gnt,
  output logic             p0_rvalid,
  output logic             p1_rvalid,
  output logic [WIDTH-1:0] p0_rdata,
  output logic [WIDTH-1:0] p1_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  arb_state_e             state;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic                   pick0;
  logic                   pick1;
  logic                   p0_rd_p0;
  logic                   p1_rd_p0;
  logic                   p0_vld_p1;
  logic                   p1_vld_p1;
  logic [WIDTH-1:0]       p0_rdata_p1;
  logic [WIDTH-1:0]       p1_rdata_p1;

  arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .p0_req    (p0_req),
    .p1_req    (p1_req),
    .state     (state),
    .burst_cnt (burst_cnt),
    .pick0     (pick0),
    .pick1     (pick1)
  );

  // Grants are blocked while reset is asserted so no strobe leaks out
  assign p0_gnt = pick0 & rst_n;
  assign p1_gnt = pick1 & rst_n;
  assign busy   = p0_gnt | p1_gnt;

  assign p0_rd_p0 = p0_gnt & ~p0_we;
  assign p1_rd_p0 = p1_gnt & ~p1_we;

  // Memory request mux: granted port drives the bus, otherwise all zeros
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_read  = ~p0_we;
      mem_write = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_read  = ~p1_we;
      mem_write = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // Ownership FSM and port-0 burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else begin
      state <= next_owner(p0_gnt, p1_gnt);
`ifdef ARB_ROUND_ROBIN_EN
      burst_cnt <= '0;
`else
      // Count only port-0 wins that made port 1 wait; saturate at the cap
      if (p1_gnt || !p1_req) begin
        burst_cnt <= '0;
      end else if (p0_gnt && (burst_cnt < BURST_CNT_W'(MAX_BURST))) begin
        burst_cnt <= burst_cnt + BURST_CNT_W'(1);
      end
`endif
    end
  end

  // ---- stage p0 -> p1: capture read data at the grant edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_vld_p1   <= 1'b0;
      p1_vld_p1   <= 1'b0;
      p0_rdata_p1 <= '0;
      p1_rdata_p1 <= '0;
    end else begin
      p0_vld_p1 <= p0_rd_p0;
      p1_vld_p1 <= p1_rd_p0;
      if (p0_rd_p0) p0_rdata_p1 <= mem_rdata;
      if (p1_rd_p0) p1_rdata_p1 <= mem_rdata;
    end
  end

  assign p0_rvalid = p0_vld_p1;
  assign p1_rvalid = p1_vld_p1;
  assign p0_rdata  = p0_rdata_p1;
  assign p1_rdata  = p1_rdata_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: scenario tasks plus a read-return scoreboard.
module tb_data_mem_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [W-1:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic         p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_read, mem_write, busy;
  logic [W-1:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

  // Second instance with a burst cap of one, sharing the request inputs
  logic         a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_mem_read, a_mem_write, a_busy;
  logic [W-1:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata;
  logic [W-1:0] a_mem_rdata = '0;

  logic [W-1:0] mem    [16];
  logic [W-1:0] shadow [16];

  typedef struct { logic [W-1:0] data; int cyc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  data_mem_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  data_mem_arbiter #(.WIDTH(W), .MAX_BURST(1)) dut_alt (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(a_p0_gnt), .p1_gnt(a_p1_gnt), .p0_rvalid(a_p0_rvalid), .p1_rvalid(a_p1_rvalid),
    .p0_rdata(a_p0_rdata), .p1_rdata(a_p1_rdata), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model: combinational read, synchronous write
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;

  // Scoreboard: push expected read data on each read grant, check one cycle later
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (p0_rvalid) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL p0_rvalid_unexpected got=1 want=0 cyc=%0d", cyc);
        end else begin
          e = q0.pop_front();
          if (p0_rdata !== e.data || cyc != e.cyc + 1) begin
            failures++;
            $display("FAIL p0_read_return got=%h@%0d want=%h@%0d", p0_rdata, cyc, e.data, e.cyc + 1);
          end
        end
      end else if (q0.size() != 0 && q0[0].cyc + 1 == cyc) begin
        checks++; failures++;
        $display("FAIL p0_rvalid_missing got=0 want=1 cyc=%0d", cyc);
        void'(q0.pop_front());
      end
      if (p1_rvalid) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL p1_rvalid_unexpected got=1 want=0 cyc=%0d", cyc);
        end else begin
          e = q1.pop_front();
          if (p1_rdata !== e.data || cyc != e.cyc + 1) begin
            failures++;
            $display("FAIL p1_read_return got=%h@%0d want=%h@%0d", p1_rdata, cyc, e.data, e.cyc + 1);
          end
        end
      end else if (q1.size() != 0 && q1[0].cyc + 1 == cyc) begin
        checks++; failures++;
        $display("FAIL p1_rvalid_missing got=0 want=1 cyc=%0d", cyc);
        void'(q1.pop_front());
      end
      if (p0_gnt && !p0_we) q0.push_back('{shadow[p0_addr[5:2]], cyc});
      if (p1_gnt && !p1_we) q1.push_back('{shadow[p1_addr[5:2]], cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic test_reset();
    p0_req = 1'b1; p0_addr = 32'h10; p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({p0_gnt, p1_gnt, busy, mem_read, mem_write, p0_rvalid, p1_rvalid} !== 7'b0) begin
        failures++;
        $display("FAIL reset_strobes got=%b want=0000000",
                 {p0_gnt, p1_gnt, busy, mem_read, mem_write, p0_rvalid, p1_rvalid});
      end
      checks++;
      if ({mem_addr, mem_wdata, p0_rdata, p1_rdata} !== '0) begin
        failures++;
        $display("FAIL reset_data got=%h/%h/%h/%h want=0", mem_addr, mem_wdata, p0_rdata, p1_rdata);
      end
    end
    idle_ports();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if ({p0_gnt, p1_gnt, mem_read, mem_write, busy} !== 5'b10101 || mem_addr !== 32'h10) begin
      failures++;
      $display("FAIL single_read_grant got=%b addr=%h want=10101 addr=00000010",
               {p0_gnt, p1_gnt, mem_read, mem_write, busy}, mem_addr);
    end
    tick();
    idle_ports();
    @(negedge clk);
    checks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL single_read_data got=%b/%h want=1/000000aa", p0_rvalid, p0_rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL single_read_hold got=%b/%h want=0/000000aa", p0_rvalid, p0_rdata);
    end
    tick();
  endtask

  task automatic test_idle();
    idle_ports();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_read, mem_write, busy, p0_gnt, p1_gnt} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
        failures++;
        $display("FAIL idle_cycle%0d got=%b addr=%h want=00000 addr=0",
                 i, {mem_read, mem_write, busy, p0_gnt, p1_gnt}, mem_addr);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    int exp_pat [10];
    int got;
    int got_alt;
`ifdef ARB_ROUND_ROBIN_EN
    exp_pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h04;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h08;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got     = (p0_gnt && !p1_gnt) ? 0 : ((p1_gnt && !p0_gnt) ? 1 : 9);
      got_alt = (a_p0_gnt && !a_p1_gnt) ? 0 : ((a_p1_gnt && !a_p0_gnt) ? 1 : 9);
      checks++;
      if (got != exp_pat[i]) begin
        failures++;
        $display("FAIL priority_cycle%0d got=%0d want=%0d", i, got, exp_pat[i]);
      end
      checks++;
      if (got_alt != (i % 2)) begin
        failures++;
        $display("FAIL burst1_cycle%0d got=%0d want=%0d", i, got_alt, i % 2);
      end
      tick();
    end
    idle_ports();
    tick();
    tick();
  endtask

  task automatic test_write_then_read();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({p0_gnt, p1_gnt, mem_read, mem_write} !== 4'b0101 || mem_addr !== 32'h20 ||
        mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_grant got=%b addr=%h data=%h want=0101 addr=00000020 data=deadbeef",
               {p0_gnt, p1_gnt, mem_read, mem_write}, mem_addr, mem_wdata);
    end
    if (p1_gnt) shadow[8] = 32'hDEAD_BEEF;
    tick();
    idle_ports();
    p0_req = 1'b1; p0_addr = 32'h20;
    @(negedge clk);
    checks++;
    if ({p0_gnt, mem_read, mem_write} !== 3'b110) begin
      failures++;
      $display("FAIL readback_grant got=%b want=110", {p0_gnt, mem_read, mem_write});
    end
    tick();
    idle_ports();
    @(negedge clk);
    checks++;
    if (p0_rdata !== 32'hDEAD_BEEF || p1_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL readback_data got=%h/%b want=deadbeef/0", p0_rdata, p1_rvalid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] p0_expect;
    p0_req = 1'b1; p0_addr = 32'h0C;
    tick();
    idle_ports();
    p1_req = 1'b1; p1_addr = 32'h18;
    tick();
    idle_ports();
    @(negedge clk);
    p0_expect = shadow[3];
    checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== shadow[6] || p0_rdata !== p0_expect || p0_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back got=p1 %b/%h p0 %b/%h want=p1 1/%h p0 0/%h",
               p1_rvalid, p1_rdata, p0_rvalid, p0_rdata, shadow[6], p0_expect);
    end
    tick();
  endtask

  task automatic test_reset_suppress();
    p0_req = 1'b1; p0_addr = 32'h10; p1_req = 1'b1; p1_addr = 32'h08;
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_grant got=%b want=1", p0_gnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({p0_rvalid, p1_rvalid, p0_gnt, p1_gnt, mem_read, mem_write, busy} !== 7'b0 ||
          {p0_rdata, p1_rdata, mem_addr} !== '0) begin
        failures++;
        $display("FAIL rst_suppress%0d got=%b rdata=%h want=0000000 rdata=0",
                 i, {p0_rvalid, p1_rvalid, p0_gnt, p1_gnt, mem_read, mem_write, busy}, p0_rdata);
      end
      if (i == 0) tick();
    end
    idle_ports();
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    tick();
    @(negedge clk);
    checks++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== '0) begin
      failures++;
      $display("FAIL rst_release got=%b/%h want=0/0", p0_rvalid, p0_rdata);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 32'hA5A5_0000 | i;
      shadow[i] = 32'hA5A5_0000 | i;
    end
    mem[4]    = 32'h0000_00AA;
    shadow[4] = 32'h0000_00AA;
    test_reset();
    test_single_read();
    test_idle();
    test_priority();
    test_write_then_read();
    test_back_to_back();
    test_reset_suppress();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data and address width in bits.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive port-0 grants while port 1 waits (fixed-priority mode only); legal range 1..15.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 p0_req, p1_req  input  1 each  port requests a memory access (p0 = CPU load/store, p1 = loader/debug).
REQ-007 p0_we, p1_we  input  1 each  1 = write, 0 = read.
REQ-008 p0_addr, p1_addr  input  WIDTH each  byte address.
REQ-009 p0_wdata, p1_wdata  input  WIDTH each  store data.
REQ-010 p0_gnt, p1_gnt  output  1 each  access accepted this cycle.
REQ-011 p0_rvalid, p1_rvalid  output  1 each  read data valid.
REQ-012 p0_rdata, p1_rdata  output  WIDTH each  registered read data.
REQ-013 mem_read, mem_write  output  1 each  data memory strobes.
REQ-014 mem_addr, mem_wdata  output  WIDTH each  data memory address and write data.
REQ-015 mem_rdata  input  WIDTH  combinational read data from data memory.
REQ-016 busy  output  1  high in any cycle where a grant is issued.

Function
REQ-017 At most one gnt SHALL be high per cycle; gnt is combinational from state and req signals in the same cycle.
REQ-018 A requester SHALL hold req, we, addr, wdata stable until it samples gnt high; the access completes at that rising edge.
REQ-019 In a granted cycle, mem_addr/mem_wdata SHALL carry the granted port's values, with mem_write = we and mem_read = !we; otherwise mem_read = mem_write = 0 and mem_addr = mem_wdata = 0.
REQ-020 For a granted read, px_rvalid SHALL pulse high exactly one cycle later, with px_rdata = mem_rdata registered at the grant edge.
REQ-021 px_rdata SHALL hold its value until the next read completes on that port; writes never assert rvalid.
REQ-022 Single requester: that port SHALL be granted the same cycle, every cycle it requests.
REQ-023 FSM states: IDLE (no grant last cycle), OWN0, OWN1 (port last granted); next state follows the granted port, or IDLE if no grant.
REQ-024 Fixed-priority mode, both requesting: p0 wins unless burst_cnt == MAX_BURST, in which case p1 is granted once.
REQ-025 burst_cnt (4 bits) SHALL increment on each p0 grant while p1_req is high, clear on any p1 grant or any cycle p1_req is low, and never exceed MAX_BURST.
REQ-026 MAX_BURST = 1 SHALL yield strict alternation p0,p1,p0,p1 under continuous dual requests.
REQ-027 Back-to-back read on one port and read on the other SHALL each produce their own rvalid with no loss or cross-routing.

Reset
REQ-028 While rst_n = 0: state = IDLE, burst_cnt = 0, all gnt/rvalid/mem strobes = 0, rdata = 0, busy = 0.
REQ-029 Reset asserted the cycle after a read grant SHALL suppress the pending rvalid; no memory strobe SHALL be issued during reset.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: on dual requests, grant the port not granted in the previous grant (OWN0 -> p1, OWN1 -> p0, IDLE -> p0); burst_cnt is unused and held at 0.
REQ-031 Macro undefined: fixed priority with burst cap per REQ-024..REQ-026.

Structure
REQ-032 FSM state enum (IDLE, OWN0, OWN1) and port index constants SHALL live in the shared CPU package.
REQ-033 One sub-module, arb_pick: combinational winner select from req pair, state and burst_cnt; all registers stay in data_mem_arbiter.

Verification
REQ-034 p0 read addr 0x10 alone, memory word 0x0000_00AA -> p0_gnt same cycle, mem_read = 1, p0_rvalid next cycle, p0_rdata = 0xAA.
REQ-035 Fixed, MAX_BURST = 4, both request continuously for 10 cycles -> grant pattern 0,0,0,0,1,0,0,0,0,1.
REQ-036 Round-robin build, both request for 6 cycles from IDLE -> 0,1,0,1,0,1.
REQ-037 p1 write 0x20 <= 0xDEAD_BEEF, then p0 read 0x20 -> mem_write one cycle, then p0_rdata = 0xDEADBEEF, p1_rvalid never asserted.
REQ-038 p0 read granted, rst_n low next cycle -> p0_rvalid stays 0; all outputs 0 until release.
REQ-039 No requests for 5 cycles -> mem_read = mem_write = busy = 0, state IDLE throughout.
